// File: rtl/meta_pkg.sv
// Shared layout of the TFE meta word and of the buffered receive entry.
package meta_pkg;

  localparam int unsigned META_W    = 144;
  localparam int unsigned PAYLOAD_W = 128;
  localparam int unsigned SIZE_W    = 16;
  localparam int unsigned ARVT_W    = 16;
  localparam int unsigned ENTRY_W   = PAYLOAD_W + SIZE_W + ARVT_W;

  localparam int unsigned TUPLE_MSB   = 127;
  localparam int unsigned TUPLE_LSB   = 24;
  localparam int unsigned TUPLE_W     = TUPLE_MSB - TUPLE_LSB + 1;
  localparam int unsigned SIZE_HI_MSB = 23;
  localparam int unsigned SIZE_HI_LSB = 16;
  localparam int unsigned FLAG_MSB    = 15;
  localparam int unsigned FLAG_LSB    = 8;
  localparam int unsigned WIND_HI_MSB = 7;
  localparam int unsigned WIND_HI_LSB = 0;

  typedef struct packed {
    logic [PAYLOAD_W-1:0] meta;
    logic [SIZE_W-1:0]    pkt_size;
    logic [ARVT_W-1:0]    arvt;
  } entry_t;

endpackage

// File: rtl/meta_fifo.sv
// Generic synchronous show-ahead FIFO; push on full and pop on empty are ignored.
module meta_fifo #(
  parameter int unsigned WIDTH = 160,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_level;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_level == (AW+1)'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;
  assign o_rdata   = r_mem[r_rptr];
  assign o_level   = r_level;

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= i_wdata;
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/meta_rx.sv
// TFE meta-feature receiver: timestamps beats, buffers them and unpacks the head entry.
module meta_rx
  import meta_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TS_W       = 20
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [META_W-1:0]             meta_i,
  input  logic                          meta_v_i,
  input  logic [SIZE_W-1:0]             pkt_size_i,
  output logic [TUPLE_W-1:0]            tuple_o,
  output logic [7:0]                    size_hi_o,
  output logic [7:0]                    flag_o,
  output logic [7:0]                    wind_hi_o,
  output logic [SIZE_W-1:0]             pkt_size_o,
  output logic [ARVT_W-1:0]             arvt_o,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [15:0]                   drop_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  logic [TS_W-1:0]   r_timer;
  logic [TS_W-1:0]   r_last_ts;
  logic              r_first;
  logic [15:0]       r_drop_cnt;
  logic [TS_W-1:0]   w_delta;
  logic [ARVT_W-1:0] w_arvt;
  logic              w_full;
  logic              w_empty;
  entry_t            w_wr_entry;
  entry_t            w_rd_entry;
  entry_t            w_head;
  logic              w_unused_bits;

  assign w_delta    = r_timer - r_last_ts;
  assign w_arvt     = r_first ? '0 : w_delta[TS_W-1 -: ARVT_W];
  assign w_wr_entry = {meta_i[PAYLOAD_W-1:0], pkt_size_i, w_arvt};

  // Reserved meta bits are not stored; the low delta bits are below arvt resolution.
  assign w_unused_bits = ^{meta_i[META_W-1:PAYLOAD_W], w_delta};

  // Arrival bookkeeping runs on every strobe, including dropped beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer    <= '0;
      r_last_ts  <= '0;
      r_first    <= 1'b1;
      r_drop_cnt <= '0;
    end else begin
      r_timer <= r_timer + 1'b1;
      if (meta_v_i) begin
        r_last_ts <= r_timer;
        r_first   <= 1'b0;
        if (w_full && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end
  end

  meta_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (meta_v_i),
    .i_wdata (w_wr_entry),
    .i_pop   (out_ready),
    .o_rdata (w_rd_entry),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

  // Stale memory contents are hidden so the fields read 0 while empty.
  assign w_head     = w_empty ? '0 : w_rd_entry;
  assign out_valid  = ~w_empty;
  assign drop_cnt   = r_drop_cnt;
  assign tuple_o    = w_head.meta[TUPLE_MSB:TUPLE_LSB];
  assign size_hi_o  = w_head.meta[SIZE_HI_MSB:SIZE_HI_LSB];
  assign flag_o     = w_head.meta[FLAG_MSB:FLAG_LSB];
  assign wind_hi_o  = w_head.meta[WIND_HI_MSB:WIND_HI_LSB];
  assign pkt_size_o = w_head.pkt_size;
  assign arvt_o     = w_head.arvt;

endmodule

// File: tb/tb_meta_rx.sv
// Self-checking bench for meta_rx: queue-based reference model, vector table and corner sequences.
module tb_meta_rx;

  localparam int DEPTH = 8;

  logic         clk;
  logic         rst_n;
  logic [143:0] meta_i;
  logic         meta_v_i;
  logic [15:0]  pkt_size_i;
  logic         out_ready;

  logic [103:0] tuple_o,   b_tuple;
  logic [7:0]   size_hi_o, b_size_hi;
  logic [7:0]   flag_o,    b_flag;
  logic [7:0]   wind_hi_o, b_wind_hi;
  logic [15:0]  pkt_size_o, b_pkt_size;
  logic [15:0]  arvt_o,    b_arvt;
  logic         out_valid, b_out_valid;
  logic [15:0]  drop_cnt,  b_drop_cnt;
  logic [3:0]   fifo_level, b_fifo_level;

  meta_rx u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .meta_i     (meta_i),
    .meta_v_i   (meta_v_i),
    .pkt_size_i (pkt_size_i),
    .tuple_o    (tuple_o),
    .size_hi_o  (size_hi_o),
    .flag_o     (flag_o),
    .wind_hi_o  (wind_hi_o),
    .pkt_size_o (pkt_size_o),
    .arvt_o     (arvt_o),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .drop_cnt   (drop_cnt),
    .fifo_level (fifo_level)
  );

  // Narrow-timer instance so a timer wrap is reachable in a short run.
  meta_rx #(.TS_W(16)) u_dut_w16 (
    .clk        (clk),
    .rst_n      (rst_n),
    .meta_i     (meta_i),
    .meta_v_i   (meta_v_i),
    .pkt_size_i (pkt_size_i),
    .tuple_o    (b_tuple),
    .size_hi_o  (b_size_hi),
    .flag_o     (b_flag),
    .wind_hi_o  (b_wind_hi),
    .pkt_size_o (b_pkt_size),
    .arvt_o     (b_arvt),
    .out_valid  (b_out_valid),
    .out_ready  (out_ready),
    .drop_cnt   (b_drop_cnt),
    .fifo_level (b_fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] meta;
    logic [15:0]  size;
    bit           first;
    longint       delta;
  } ment_t;

  typedef struct {
    logic v;
    logic rdy;
    int   exp_level;
    int   exp_drop;
  } vec_t;

  ment_t  mq[$];
  longint mcyc;
  longint m_last;
  bit     m_first;
  int     m_drop;
  int     n_tests;
  int     n_fail;

  function automatic logic [15:0] arvt_of(input ment_t e, input int w);
    longint d;
    if (e.first) return 16'h0;
    d = e.delta % (longint'(1) << w);
    return 16'(d >> (w - 16));
  endfunction

  function automatic logic [143:0] beat_meta(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {16'h0, {13{b ^ 8'hA5}}, b, 8'(i * 3 + 1), 8'(i * 7 + 2)};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outputs();
    ment_t h;
    chk("out_valid", 128'(out_valid), 128'(mq.size() != 0));
    chk("fifo_level", 128'(fifo_level), 128'(mq.size()));
    chk("drop_cnt", 128'(drop_cnt), 128'(m_drop));
    chk("w16_out_valid", 128'(b_out_valid), 128'(mq.size() != 0));
    if (mq.size() != 0) begin
      h = mq[0];
      chk("tuple_o", 128'(tuple_o), 128'(h.meta[127:24]));
      chk("size_hi_o", 128'(size_hi_o), 128'(h.meta[23:16]));
      chk("flag_o", 128'(flag_o), 128'(h.meta[15:8]));
      chk("wind_hi_o", 128'(wind_hi_o), 128'(h.meta[7:0]));
      chk("pkt_size_o", 128'(pkt_size_o), 128'(h.size));
      chk("arvt_o", 128'(arvt_o), 128'(arvt_of(h, 20)));
      chk("w16_arvt_o", 128'(b_arvt), 128'(arvt_of(h, 16)));
    end
  endtask

  // Drive one cycle, advance the model across the edge, then compare.
  task automatic step(input logic v, input logic [143:0] m, input logic [15:0] sz,
                      input logic rdy);
    ment_t e;
    bit    push;
    bit    pop;
    meta_v_i   = v;
    meta_i     = m;
    pkt_size_i = sz;
    out_ready  = rdy;
    push = v && (mq.size() < DEPTH);
    pop  = (mq.size() != 0) && rdy;
    if (v) begin
      e.meta  = m[127:0];
      e.size  = sz;
      e.first = m_first;
      e.delta = mcyc - m_last;
      m_last  = mcyc;
      m_first = 1'b0;
      if (!push && m_drop != 65535) m_drop++;
    end
    @(posedge clk);
    mcyc++;
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back(e);
    #1;
    check_outputs();
  endtask

  task automatic idle_until(input longint t, input logic rdy);
    while (mcyc < t) step(1'b0, '0, '0, rdy);
  endtask

  task automatic model_clear();
    mq.delete();
    mcyc    = 0;
    m_last  = 0;
    m_first = 1'b1;
    m_drop  = 0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_out_valid"}, 128'(out_valid), 128'(0));
    chk({tag, "_fifo_level"}, 128'(fifo_level), 128'(0));
    chk({tag, "_drop_cnt"}, 128'(drop_cnt), 128'(0));
    chk({tag, "_tuple_o"}, 128'(tuple_o), 128'(0));
    chk({tag, "_pkt_size_o"}, 128'(pkt_size_o), 128'(0));
    chk({tag, "_arvt_o"}, 128'(arvt_o), 128'(0));
    chk({tag, "_w16_out_valid"}, 128'(b_out_valid), 128'(0));
  endtask

  task automatic do_reset(input string tag);
    meta_v_i   = 1'b0;
    meta_i     = '0;
    pkt_size_i = '0;
    out_ready  = 1'b0;
    rst_n      = 1'b0;
    #2;
    model_clear();
    reset_checks(tag);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  vec_t         tbl [19];
  logic [143:0] m_single;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    tbl = '{'{1, 0, 1, 0}, '{1, 0, 2, 0}, '{1, 0, 3, 0}, '{1, 0, 4, 0}, '{1, 0, 5, 0},
            '{1, 0, 6, 0}, '{1, 0, 7, 0}, '{1, 0, 8, 0}, '{1, 0, 8, 1}, '{1, 0, 8, 2},
            '{1, 1, 7, 3}, '{0, 1, 6, 3}, '{0, 1, 5, 3}, '{0, 1, 4, 3}, '{0, 1, 3, 3},
            '{0, 1, 2, 3}, '{0, 1, 1, 3}, '{0, 1, 0, 3}, '{0, 1, 0, 3}};

    do_reset("reset");

    // Single beat: visible after one edge with first-beat arvt of 0.
    m_single = {16'h0, 104'h1234_5678_9ABC_DEF0_1357_9BDF_02, 8'h05, 8'h12, 8'h40};
    step(1'b1, m_single, 16'h05DC, 1'b0);
    chk("single_valid", 128'(out_valid), 128'(1));
    chk("single_tuple", 128'(tuple_o), 128'(104'h1234_5678_9ABC_DEF0_1357_9BDF_02));
    chk("single_size_hi", 128'(size_hi_o), 128'(8'h05));
    chk("single_flag", 128'(flag_o), 128'(8'h12));
    chk("single_pkt_size", 128'(pkt_size_o), 128'(16'h05DC));
    chk("single_arvt", 128'(arvt_o), 128'(0));
    step(1'b0, '0, '0, 1'b0);
    chk("stall_flag_stable", 128'(flag_o), 128'(8'h12));
    step(1'b0, '0, '0, 1'b1);
    chk("single_popped", 128'(out_valid), 128'(0));

    // Inter-arrival: beats at timer 100 and 420 give 320 >> 4.
    do_reset("reset_ia");
    idle_until(100, 1'b1);
    step(1'b1, beat_meta(1), 16'h0100, 1'b1);
    idle_until(420, 1'b1);
    step(1'b1, beat_meta(2), 16'h0200, 1'b1);
    chk("interarrival_arvt", 128'(arvt_o), 128'(20));

    // Random traffic, then a beat pair straddling the 16-bit timer wrap.
    do_reset("reset_rand");
    while (mcyc < 65500) begin
      step(1'($urandom_range(0, 9) < 6),
           {16'h0, $urandom(), $urandom(), $urandom(), $urandom()},
           16'($urandom()), 1'($urandom_range(0, 9) < 4));
    end
    idle_until(65520, 1'b1);
    step(1'b1, beat_meta(3), 16'h0300, 1'b1);
    idle_until(65568, 1'b1);
    step(1'b1, beat_meta(4), 16'h0400, 1'b1);
    chk("wrap_arvt_w16", 128'(b_arvt), 128'(48));
    chk("wrap_arvt_w20", 128'(arvt_o), 128'(3));

    // Overflow, full-with-pop and drain from the vector table.
    do_reset("reset_ovf");
    for (int i = 0; i < 19; i++) begin
      step(tbl[i].v, beat_meta(i + 16), 16'(16'h1000 + i), tbl[i].rdy);
      chk($sformatf("ovf[%0d]_level", i), 128'(fifo_level), 128'(tbl[i].exp_level));
      chk($sformatf("ovf[%0d]_drop", i), 128'(drop_cnt), 128'(tbl[i].exp_drop));
    end

    // Asynchronous reset with entries queued and a non-zero drop count.
    for (int i = 0; i < 3; i++) step(1'b1, beat_meta(i + 40), 16'h0777, 1'b0);
    chk("pre_reset_level", 128'(fifo_level), 128'(3));
    rst_n = 1'b0;
    #2;
    model_clear();
    reset_checks("async_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_until(40, 1'b0);
    step(1'b1, beat_meta(50), 16'h0888, 1'b0);
    chk("post_reset_arvt", 128'(arvt_o), 128'(0));
    chk("post_reset_valid", 128'(out_valid), 128'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/meta_rx.md
# meta_rx

Receiving end of the TFE meta-feature stream. It accepts the 144-bit meta word, its valid strobe and the full packet size from the meta generator, which applies no backpressure. Each accepted word is timestamped against a local free-running timer and tagged with its inter-arrival time. The word is then buffered in a small FIFO, unpacked into named fields, and presented to the downstream feature/inference stage over a valid/ready handshake.

## Interface

Parameters:
- FIFO_DEPTH, 8, entry count; power of two, ≥2
- TS_W, 20, timer/timestamp width in bits

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- meta_i  in  144  meta word; [143:128] reserved (zero), [127:24] 5-tuple, [23:16] pkt size high byte, [15:8] TCP flags, [7:0] window high byte
- meta_v_i  in  1  meta_i/pkt_size_i valid, single-cycle strobe, no backpressure
- pkt_size_i  in  16  full packet size, qualified by meta_v_i
- tuple_o  out  104  5-tuple of head entry
- size_hi_o  out  8  pkt size high byte of head entry
- flag_o  out  8  flags of head entry
- wind_hi_o  out  8  window high byte of head entry
- pkt_size_o  out  16  full packet size of head entry
- arvt_o  out  16  inter-arrival time of head entry, units of 16 cycles
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts head entry
- drop_cnt  out  16  saturating count of beats dropped on full FIFO
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy

## Operation

- Timer: TS_W-bit counter, 0 at reset, +1 every cycle, wraps modulo 2^TS_W.
- On every meta_v_i=1 cycle (accepted or dropped):
  - delta = (timer − last_ts) mod 2^TS_W
  - last_ts ← timer
  - first ← 0
- arvt for a beat = 0 if first=1, else delta[TS_W-1:TS_W-16]. This is delta[19:4] at TS_W=20.
- Gaps ≥2^TS_W cycles alias; this is accepted behaviour.
- Write: meta_v_i=1 and FIFO not full → push {meta_i[127:0], pkt_size_i, arvt}. The reserved bits are not stored.
- Full evaluation: "full" is the occupancy at the start of the cycle. A simultaneous pop does not free a slot for that cycle's write.
- Drop: meta_v_i=1 and full → beat discarded; drop_cnt +1, saturating at 16'hFFFF.
- Read: show-ahead FIFO; out_valid = (level≠0). Pop when out_valid & out_ready.
- out_ready with out_valid=0 has no effect.
- Simultaneous push and pop leaves level unchanged.
- Outputs are combinational decodes of the head entry. They are don't-care when out_valid=0, but are driven 0 after reset.

## Timing

- Reset values: out_valid=0, all data outputs=0, drop_cnt=0, fifo_level=0, timer=0, last_ts=0, first=1.
- Latency: a beat with meta_v_i=1 at edge N gives out_valid=1 after edge N+1 when the FIFO was empty. There is no bypass.
- Throughput: one push and one pop per cycle.
- Downstream stall: out_valid and the head fields stay stable while out_ready=0.
- Reset mid-operation: all entries are discarded immediately (asynchronous), and timer/first are re-initialised. The first beat after reset reports arvt=0.
- fifo_level and drop_cnt are registered and reflect the previous edge.

## Structure

- Package meta_pkg holds:
  - meta field offsets/widths (TUPLE 127:24, SIZE_HI 23:16, FLAG 15:8, WIND_HI 7:0)
  - META_W=144
  - entry width = 128+16+16 = 160
- Sub-module meta_fifo: generic synchronous show-ahead FIFO (WIDTH, DEPTH) with push, pop, full, empty and level.
- meta_rx holds the timer, arrival logic, drop counter and field unpack.

## Test plan

- Single beat: meta_v_i=1 with tuple=104'h1234…, flags=8'h12, pkt_size_i=16'h05DC → next cycle out_valid=1, fields match, size_hi_o=8'h05, arvt_o=0.
- Inter-arrival: beats at timer values 100 and 420 with out_ready=1 → second entry arvt_o=20 (320>>4).
- Wrap: first beat at timer=2^20−16, second 48 cycles later → arvt_o=3.
- Overflow: out_ready=0, 10 consecutive beats → fifo_level=8, drop_cnt=2; draining yields the first 8 beats in order.
- Full with simultaneous pop: FIFO full, meta_v_i=1 and out_ready=1 in the same cycle → beat dropped (drop_cnt+1), level becomes 7.
- Reset mid-stream: 3 entries queued, rst_n pulsed → out_valid=0, level=0, drop_cnt=0; the next beat reports arvt_o=0.
